// File: rtl/video_timing_pkg.sv
// Shared constants and types for the video raster timing path.
// Default timing is 640x480@60 on a 25 MHz pixel clock.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vtg_state_e;

  // Half-open window test on a raster position: lo <= pos < hi.
  function automatic logic in_window(input int unsigned pos,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_2ff.sv
// Generic 2-flop synchronizer with asynchronous active-low reset.
// Used for the PLL lock input; reusable anywhere in the video path.
module sync_2ff #(
  parameter int                WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered hsync/vsync/de, pixel coordinates and
// line/frame strobes. Optional frame counter under VIDEO_TIMING_FRAME_COUNT_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

  logic run;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (run)
  );

  vtg_state_e state_q, state_d;
  logic       run_en;

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [15:0]   frame_count_q, frame_count_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run)  state_d = RUN;
      RUN:     if (!run) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Counters and output registers key off the state being entered, so the
  // first RUN edge already registers position (0,0) and a drop clears on
  // the very edge the FSM returns to IDLE.
  always_comb begin
    run_en        = (state_d == RUN);
    h_d           = '0;
    v_d           = '0;
    hsync_d       = ~HSYNC_POL;
    vsync_d       = ~VSYNC_POL;
    de_d          = 1'b0;
    x_d           = '0;
    y_d           = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    frame_count_d = '0;
`endif
    if (run_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
      x_d           = h_q;
      y_d           = v_q;
      de_d          = in_window(int'(h_q), 0, H_ACTIVE) &&
                      in_window(int'(v_q), 0, V_ACTIVE);
      hsync_d       = in_window(int'(h_q), HS_BEG, HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = in_window(int'(v_q), VS_BEG, VS_END) ? VSYNC_POL : ~VSYNC_POL;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_count_q <= '0;
    else        frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small-parameter and default instances
// share clock, reset and locked; expectations come from raster arithmetic.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic locked;

  always #5 clk = ~clk;

  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [2:0] s_x, s_y;
  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
  logic [15:0] s_fc, d_fc;
  int          fc_off = 0;
`endif

  video_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .locked      (locked),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .de          (s_de),
    .x           (s_x),
    .y           (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    ,
    .frame_count (s_fc)
`endif
  );

  video_timing_gen u_dflt (
    .clk         (clk),
    .rst_n       (rst_n),
    .locked      (locked),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .de          (d_de),
    .x           (d_x),
    .y           (d_y),
    .line_start  (d_ls),
    .frame_start (d_fs)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    ,
    .frame_count (d_fc)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, " s_hs"}, 32'(s_hs), 0);
    check({tag, " s_vs"}, 32'(s_vs), 1);
    check({tag, " s_de"}, 32'(s_de), 0);
    check({tag, " s_x"},  32'(s_x),  0);
    check({tag, " s_y"},  32'(s_y),  0);
    check({tag, " s_ls"}, 32'(s_ls), 0);
    check({tag, " s_fs"}, 32'(s_fs), 0);
    check({tag, " d_hs"}, 32'(d_hs), 1);
    check({tag, " d_vs"}, 32'(d_vs), 1);
    check({tag, " d_de"}, 32'(d_de), 0);
    check({tag, " d_x"},  32'(d_x),  0);
    check({tag, " d_y"},  32'(d_y),  0);
    check({tag, " d_ls"}, 32'(d_ls), 0);
    check({tag, " d_fs"}, 32'(d_fs), 0);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    check({tag, " s_fc"}, 32'(s_fc), 0);
    check({tag, " d_fc"}, 32'(d_fc), 0);
`endif
  endtask

  // t = clocks since the (0,0) sample of the current run.
  task automatic chk_run(input int t);
    int sx, sy, dx, dy;
    sx = t % 8;
    sy = (t / 8) % 6;
    dx = t % 800;
    dy = (t / 800) % 525;
    check("run s_x",  32'(s_x),  sx);
    check("run s_y",  32'(s_y),  sy);
    check("run s_hs", 32'(s_hs), 32'(sx == 5 || sx == 6));
    check("run s_vs", 32'(s_vs), 32'(sy != 4));
    check("run s_de", 32'(s_de), 32'(sx < 4 && sy < 3));
    check("run s_ls", 32'(s_ls), 32'(sx == 0));
    check("run s_fs", 32'(s_fs), 32'(t % 48 == 0));
    check("run d_x",  32'(d_x),  dx);
    check("run d_y",  32'(d_y),  dy);
    check("run d_hs", 32'(d_hs), 32'(!(dx >= 656 && dx < 752)));
    check("run d_vs", 32'(d_vs), 32'(!(dy == 490 || dy == 491)));
    check("run d_de", 32'(d_de), 32'(dx < 640 && dy < 480));
    check("run d_ls", 32'(d_ls), 32'(dx == 0));
    check("run d_fs", 32'(d_fs), 32'(t % 420000 == 0));
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    check("run s_fc", 32'(s_fc), 32'(16'(fc_off + t / 48 + 1)));
    check("run d_fc", 32'(d_fc), 1);
`endif
  endtask

  // Raise locked just after a falling edge; outputs stay idle after edges
  // k and k+1 and read (0,0) after edge k+2.
  task automatic startup(input string tag);
    locked = 1'b1;
    @(negedge clk); chk_idle({tag, " k"});
    @(negedge clk); chk_idle({tag, " k+1"});
    @(negedge clk); chk_run(0);
  endtask

  int hs_low, hs_first;

  initial begin
    rst_n  = 1'b0;
    locked = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("unlocked");

    startup("start");
    for (int t = 1; t <= 106; t++) begin
      @(negedge clk);
      chk_run(t);
    end

    // t=106 is small (2,1), mid-frame; two more edges still advance.
    locked = 1'b0;
    @(negedge clk); chk_run(107);
    @(negedge clk); chk_run(108);
    @(negedge clk); chk_idle("drop");
    repeat (2) begin
      @(negedge clk); chk_idle("dropped");
    end

    startup("relock");
    hs_low   = 0;
    hs_first = -1;
    for (int t = 1; t <= 1700; t++) begin
      @(negedge clk);
      chk_run(t);
      if (t < 800 && d_hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_x);
      end
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      if (t == 47) begin
        force u_small.frame_count_q = 16'hFFFF;
        #1 release u_small.frame_count_q;
        fc_off = 16'hFFFF - 1;
      end
`endif
    end
    check("d_hs low count", 32'(hs_low), 96);
    check("d_hs first x", 32'(hs_first), 656);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle("async rst");
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    fc_off = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    startup("post rst");
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      chk_run(t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
